alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised-width ALU with a valid/ready handshake on both sides. It is the successor to the combinational `alu`, which it instantiates for all single-cycle operations. It adds registered outputs, backpressure, and an iterative shift-add unsigned multiply, so the datapath can sit between pipeline stages of the CPU.

## Interface
Parameters:
- `N`, default 32: operand and result width. Any N ≥ 4 is legal.
- `CW`, default `$clog2(N+1)`: width of the multiply iteration counter. Derived; never overridden.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `i_valid` in 1: request present on `a`, `b`, `control`, `mul`.
- `i_ready` out 1: block can accept a request this cycle.
- `a` in N: operand A.
- `b` in N: operand B.
- `control` in `alu_control_t`: operation, as defined in `alu_types.sv`. Ignored when `mul` = 1.
- `mul` in 1: 1 selects unsigned multiply (low N bits of a*b).
- `o_valid` out 1: result registers hold a completed result.
- `o_ready` in 1: consumer takes the result this cycle.
- `result` out N: registered result.
- `overflow` out 1: registered overflow flag.
- `zero` out 1: registered, equals (`result` == 0).
- `equal` out 1: registered, equals (`a` == `b`) of the accepted operands.
- `busy` out 1: high in states MUL and DONE.

## Operation
- FSM states: IDLE, MUL, DONE. Reset state is IDLE.
- `i_ready` = (state == IDLE) && !`rst`.
- A request is accepted when `i_valid` && `i_ready`. At accept, `a`, `b`, `control` and `mul` are captured into operand registers.
- IDLE, accept, `mul` = 0:
  - `result`, `overflow` and `equal` are loaded from the internal `alu` instance, using the live inputs.
  - `zero` is computed from the new result.
  - Next state is DONE.
- IDLE, accept, `mul` = 1:
  - Clear the 2N-bit accumulator.
  - Load the multiplicand (zero-extended to 2N bits) and the multiplier.
  - Set the counter to N. Next state is MUL.
- MUL, each cycle:
  - If multiplier[0] is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Decrement the counter.
  - When the counter reaches 1 in a cycle, that cycle performs the final step and the next state is DONE. On entry to DONE:
    - `result` = acc[N-1:0].
    - `overflow` = |acc[2N-1:N].
    - `zero` = (acc[N-1:0] == 0).
    - `equal` = captured a == captured b.
- DONE: `o_valid` = 1. When `o_ready` is high, go to IDLE. Outputs hold their values until the next completion.
- While `o_valid` is high and `o_ready` is low, `result` and all flags are stable.
- Reset values: state IDLE, `o_valid` 0, `result` 0, `overflow` 0, `zero` 0, `equal` 0, `busy` 0, accumulator 0, counter 0.
- Reset asserted in MUL or DONE aborts the operation. No `o_valid` pulse follows, and the pending result is discarded.
- `i_valid` while busy is ignored. The producer must hold its request until `i_ready` is high.
- `mul` with a = 0 or b = 0 still takes N iterations. There is no early termination.

## Timing
- Non-multiply: accept at edge k. `o_valid` is high from edge k+1. Minimum occupancy is 2 cycles (DONE plus the return to IDLE).
- Multiply: accept at edge k. `o_valid` is high from edge k+N+1.
- `o_valid` falls on the edge after the cycle in which `o_ready` is high. `i_ready` rises in that same cycle.
- Minimum throughput is 1 operation per 2 cycles when `o_ready` is held high.
- Outputs are driven only from flops. There is no combinational path from `a`/`b` to `result`.
- `i_ready` depends on state only. There is no combinational path from `o_ready` to `i_ready`.

## Test plan
- Reset, then release: all outputs are 0 and `i_ready` is 1. ADD a=5, b=7 → after 1 cycle `o_valid`=1, result=0x0000000C, zero=0, equal=0.
- SUB a=b=0x1234 with `o_ready` held low for 5 cycles → result 0, zero=1, equal=1. Values are stable for all 5 cycles, and `i_ready` stays 0 until `o_ready`.
- MUL a=0x0001_0000, b=0x0001_0000 (N=32) → `o_valid` exactly 33 cycles after accept, result=0, overflow=1, zero=1.
- MUL a=0xFFFF, b=0xFFFF → result 0xFFFE0001, overflow=0. Repeat with N=8, a=0x0F, b=0x11 → result 0xFF, overflow=0.
- Assert `rst` for 1 cycle 10 cycles into a MUL → no `o_valid` appears, and `i_ready`=1 on the next cycle. A following ADD 1+1 returns 2.
- Back-to-back: every op in `alu_control_t` × 25 random operand pairs with `o_ready` held high. Each result must match `alu_behavioural`, with no dropped or duplicated `o_valid` pulses.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops come from the combinational alu, and multiply
// is an N-step shift-add. All outputs are registered behind a valid/ready handshake.

package alu_types_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_control_t;
endpackage

module alu
    import alu_types_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  alu_control_t  control,
    output logic [N-1:0]  result,
    output logic          overflow,
    output logic          zero,
    output logic          equal
);
    localparam int SW = $clog2(N);

    logic [SW-1:0] shamt;
    logic [N-1:0]  sum;
    logic [N-1:0]  diff;

    assign shamt = b[SW-1:0];
    assign sum   = a + b;
    assign diff  = a - b;

    // Overflow is signed overflow for ADD/SUB and 0 for every other operation.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (control)
            ALU_ADD: begin
                result   = sum;
                overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            ALU_SLT: result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero  = (result == '0);
    assign equal = (a == b);
endmodule

module alu_mc
    import alu_types_pkg::*;
#(
    parameter int N  = 32,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  alu_control_t  control,
    input  logic          mul,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [N-1:0]  result,
    output logic          overflow,
    output logic          zero,
    output logic          equal,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  mcand;
    logic [2*N-1:0]  acc_step;
    logic [N-1:0]    mplier;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [CW-1:0]   count;
    logic [N-1:0]    alu_result;
    logic            alu_overflow;
    logic            alu_zero;
    logic            alu_equal;
    logic            accept;
    logic            last_step;

    alu #(.N(N)) u_alu (
        .a        (a),
        .b        (b),
        .control  (control),
        .result   (alu_result),
        .overflow (alu_overflow),
        .zero     (alu_zero),
        .equal    (alu_equal)
    );

    assign accept    = i_valid && i_ready;
    assign acc_step  = mplier[0] ? (acc + mcand) : acc;
    assign last_step = (count == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        i_ready    = 1'b0;
        o_valid    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                i_ready = !rst;
                if (i_valid && !rst) state_next = mul ? MUL : DONE;
            end
            MUL: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                o_valid = 1'b1;
                if (o_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers only change on accept of a single-cycle op or on the last
    // multiply step, so they hold steady for the whole DONE stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            equal    <= 1'b0;
        end else if (accept) begin
            op_a <= a;
            op_b <= b;
            if (mul) begin
                acc    <= '0;
                mcand  <= {{N{1'b0}}, a};
                mplier <= b;
                count  <= CW'(N);
            end else begin
                result   <= alu_result;
                overflow <= alu_overflow;
                zero     <= alu_zero;
                equal    <= alu_equal;
            end
        end else if (state == MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
            if (last_step) begin
                result   <= acc_step[N-1:0];
                overflow <= |acc_step[2*N-1:N];
                zero     <= (acc_step[N-1:0] == '0);
                equal    <= (op_a == op_b);
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: a queue-based arithmetic model checks every
// valid output cycle, plus directed literal cases and a small N=8 multiply run.

module tb_alu_mc;
    import alu_types_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic [31:0]   a = '0;
    logic [31:0]   b = '0;
    alu_control_t  control = ALU_ADD;
    logic          mul = 1'b0;
    logic          o_valid;
    logic          o_ready = 1'b1;
    logic [31:0]   result;
    logic          overflow;
    logic          zero;
    logic          equal;
    logic          busy;

    logic          i_valid8 = 1'b0;
    logic          i_ready8;
    logic [7:0]    a8 = '0;
    logic [7:0]    b8 = '0;
    alu_control_t  control8 = ALU_ADD;
    logic          mul8 = 1'b1;
    logic          o_valid8;
    logic          o_ready8 = 1'b1;
    logic [7:0]    result8;
    logic          overflow8;
    logic          zero8;
    logic          equal8;
    logic          busy8;

    int checks = 0;
    int passed = 0;
    int cycle  = 0;
    int ready_mode = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        zr;
        logic        eq;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t q[$];
    bit   head_seen = 0;

    alu_mc #(.N(32)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .a(a), .b(b), .control(control), .mul(mul),
        .o_valid(o_valid), .o_ready(o_ready), .result(result),
        .overflow(overflow), .zero(zero), .equal(equal), .busy(busy)
    );

    alu_mc #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .i_valid(i_valid8), .i_ready(i_ready8),
        .a(a8), .b(b8), .control(control8), .mul(mul8),
        .o_valid(o_valid8), .o_ready(o_ready8), .result(result8),
        .overflow(overflow8), .zero(zero8), .equal(equal8), .busy(busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       o_ready = 1'b1;
            1:       o_ready = 1'b0;
            default: o_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    endtask

    function automatic longint sval(input longint unsigned x, input int w);
        if (x[w-1]) return longint'(x) - (longint'(1) << w);
        return longint'(x);
    endfunction

    // Reference ALU written as plain integer arithmetic on w-bit values.
    function automatic void model(input int w, input longint unsigned x, input longint unsigned y,
                                  input alu_control_t c, input logic m,
                                  output longint unsigned res, output logic ovf);
        longint unsigned mask;
        longint unsigned prod;
        longint s;
        longint lim;
        mask = (64'd1 << w) - 64'd1;
        lim  = longint'(1) << (w - 1);
        res  = 0;
        ovf  = 1'b0;
        s    = 0;
        if (m) begin
            prod = x * y;
            res  = prod & mask;
            ovf  = (prod >> w) != 0;
        end else begin
            case (c)
                ALU_ADD: begin
                    s   = sval(x, w) + sval(y, w);
                    res = longint'(unsigned'(s)) & mask;
                    ovf = (s >= lim) || (s < -lim);
                end
                ALU_SUB: begin
                    s   = sval(x, w) - sval(y, w);
                    res = longint'(unsigned'(s)) & mask;
                    ovf = (s >= lim) || (s < -lim);
                end
                ALU_AND: res = x & y;
                ALU_OR:  res = x | y;
                ALU_XOR: res = x ^ y;
                ALU_SLL: res = (x << (y % w)) & mask;
                ALU_SRL: res = x >> (y % w);
                ALU_SLT: res = (sval(x, w) < sval(y, w)) ? 1 : 0;
                default: res = 0;
            endcase
        end
    endfunction

    // Scoreboard: push the model's answer at accept, check every valid cycle.
    always @(negedge clk) begin
        exp_t e;
        longint unsigned r;
        logic o;
        if (rst) begin
            q.delete();
            head_seen = 0;
        end else begin
            check_output("busy", busy, q.size() != 0);
            if (o_valid) begin
                if (q.size() == 0) begin
                    check_output("spurious_valid", o_valid, 0);
                end else begin
                    check_output("result", result, q[0].res);
                    check_output("overflow", overflow, q[0].ovf);
                    check_output("zero", zero, q[0].zr);
                    check_output("equal", equal, q[0].eq);
                    check_output("i_ready_while_valid", i_ready, 0);
                    if (!head_seen) begin
                        check_output("latency", 64'(cycle - q[0].acc_cyc), 64'(q[0].lat));
                        head_seen = 1;
                    end
                    if (o_ready) begin
                        void'(q.pop_front());
                        head_seen = 0;
                    end
                end
            end
            if (i_valid && i_ready) begin
                model(32, a, b, control, mul, r, o);
                e.res     = r[31:0];
                e.ovf     = o;
                e.zr      = (r[31:0] == 0);
                e.eq      = (a == b);
                e.acc_cyc = cycle;
                e.lat     = mul ? 33 : 1;
                q.push_back(e);
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] ta, input logic [31:0] tb, input alu_control_t c,
                                  input logic m, output int acc_cyc);
        bit ok;
        ok      = 0;
        acc_cyc = -1;
        a = ta; b = tb; control = c; mul = m; i_valid = 1'b1;
        for (int g = 0; g < 200 && !ok; g++) begin
            @(negedge clk);
            if (i_ready) begin
                ok      = 1;
                acc_cyc = cycle;
            end
        end
        check_output("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        a = $urandom; b = $urandom;
        control = alu_control_t'($urandom_range(0, 7));
        mul = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(output int vcyc);
        bit ok;
        ok   = 0;
        vcyc = -1;
        for (int g = 0; g < 200 && !ok; g++) begin
            @(negedge clk);
            if (o_valid) begin
                ok   = 1;
                vcyc = cycle;
            end
        end
        check_output("result_timeout", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int g = 0; g < 500 && !ok; g++) begin
            @(negedge clk);
            if (q.size() == 0 && i_ready && !o_valid) ok = 1;
        end
        check_output("idle_timeout", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul8(input logic [7:0] x, input logic [7:0] y);
        bit ok;
        int acc_cyc;
        longint unsigned r;
        logic o;
        ok = 0;
        acc_cyc = 0;
        a8 = x; b8 = y; i_valid8 = 1'b1;
        for (int g = 0; g < 100 && !ok; g++) begin
            @(negedge clk);
            if (i_ready8) begin
                ok = 1;
                acc_cyc = cycle;
            end
        end
        check_output("accept8_timeout", ok, 1);
        @(posedge clk);
        #1;
        i_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        ok = 0;
        for (int g = 0; g < 100 && !ok; g++) begin
            @(negedge clk);
            if (o_valid8) ok = 1;
        end
        check_output("result8_timeout", ok, 1);
        model(8, x, y, ALU_ADD, 1'b1, r, o);
        check_output("latency8", 64'(cycle - acc_cyc), 9);
        check_output("result8", result8, r[7:0]);
        check_output("overflow8", overflow8, o);
        check_output("zero8", zero8, r[7:0] == 0);
        check_output("equal8", equal8, x == y);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_cyc;
        int vcyc;
        int seen_valid;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_result", result, 0);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_zero", zero, 0);
        check_output("rst_equal", equal, 0);
        check_output("rst_o_valid", o_valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_i_ready", i_ready, 1);
        @(posedge clk);
        #1;

        apply_stimulus(32'd5, 32'd7, ALU_ADD, 1'b0, acc_cyc);
        wait_result(vcyc);
        check_output("add_latency", 64'(vcyc - acc_cyc), 1);
        check_output("add_result", result, 32'h0000_000C);
        check_output("add_zero", zero, 0);
        check_output("add_equal", equal, 0);
        wait_idle();

        ready_mode = 1;
        apply_stimulus(32'h1234, 32'h1234, ALU_SUB, 1'b0, acc_cyc);
        wait_result(vcyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("stall_result", result, 0);
            check_output("stall_zero", zero, 1);
            check_output("stall_equal", equal, 1);
            check_output("stall_o_valid", o_valid, 1);
            check_output("stall_i_ready", i_ready, 0);
        end
        ready_mode = 0;
        wait_idle();

        apply_stimulus(32'h0001_0000, 32'h0001_0000, ALU_ADD, 1'b1, acc_cyc);
        wait_result(vcyc);
        check_output("mul_latency", 64'(vcyc - acc_cyc), 33);
        check_output("mul_big_result", result, 0);
        check_output("mul_big_overflow", overflow, 1);
        check_output("mul_big_zero", zero, 1);
        wait_idle();

        apply_stimulus(32'hFFFF, 32'hFFFF, ALU_SUB, 1'b1, acc_cyc);
        wait_result(vcyc);
        check_output("mul_ffff_result", result, 32'hFFFE_0001);
        check_output("mul_ffff_overflow", overflow, 0);
        wait_idle();

        // Abort a multiply mid-flight with a one-cycle reset.
        apply_stimulus(32'h0000_0123, 32'h0000_0456, ALU_ADD, 1'b1, acc_cyc);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("abort_i_ready", i_ready, 1);
        check_output("abort_busy", busy, 0);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_valid) seen_valid++;
        end
        check_output("abort_no_valid", 64'(seen_valid), 0);
        @(posedge clk);
        #1;
        apply_stimulus(32'd1, 32'd1, ALU_ADD, 1'b0, acc_cyc);
        wait_result(vcyc);
        check_output("post_abort_add", result, 2);
        wait_idle();

        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 25; k++) begin
                apply_stimulus($urandom, (k % 5 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                               alu_control_t'(op), 1'b0, acc_cyc);
            end
        end
        wait_idle();

        ready_mode = 2;
        for (int k = 0; k < 30; k++) begin
            apply_stimulus($urandom, (k % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                           alu_control_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), acc_cyc);
        end
        ready_mode = 0;
        wait_idle();

        run_mul8(8'h0F, 8'h11);
        check_output("mul8_literal", result8, 8'hFF);
        check_output("mul8_literal_ovf", overflow8, 0);
        for (int k = 0; k < 8; k++) run_mul8(8'($urandom), 8'($urandom));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
